// File: rtl/mem_port_arbiter.sv
// Shares one memory-bus port between fetch and load/store; one outstanding transaction, grant registered 1 cycle after request.
// Requesters hold until their ack (stalls asserted meanwhile); MEM wins ties unless IF has waited STARVE_MAX grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_ack_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_stall_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic                mem_ack_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_stall_o,
  input  logic                flush_i,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wstrb_o,
  input  logic                bus_ack_i,
  input  logic [DATA_W-1:0]   bus_rdata_i
);

  localparam int         STRB_W     = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_IF = 2'd1, GNT_MEM = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                discard_q, discard_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [STRB_W-1:0]   bus_wstrb_q, bus_wstrb_d;
  logic                if_gnt_ok, if_wins;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    discard_d    = discard_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    if_ack_o     = 1'b0;
    mem_ack_o    = 1'b0;
    // A fetch being flushed in the same cycle is not worth starting.
    if_gnt_ok    = if_req_i & ~flush_i;
    if_wins      = if_gnt_ok & (~mem_req_i | (starve_cnt_q == STARVE_LIM));

    case (state_q)
      IDLE: begin
        if (if_wins) begin
          state_d      = GNT_IF;
          bus_req_d    = 1'b1;
          bus_we_d     = 1'b0;
          bus_addr_d   = if_addr_i;
          bus_wdata_d  = '0;
          bus_wstrb_d  = '0;
          starve_cnt_d = 4'd0;
        end else if (mem_req_i) begin
          state_d     = GNT_MEM;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_wdata_i;
          bus_wstrb_d = mem_wstrb_i;
          if (if_req_i && (starve_cnt_q < STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end
      end
      GNT_IF: begin
        if (flush_i) begin
          discard_d = 1'b1;
        end
        if (bus_ack_i) begin
          // Flush in the ack cycle itself also drops the stale fetch data.
          if_ack_o  = ~(discard_q | flush_i);
          state_d   = IDLE;
          bus_req_d = 1'b0;
          discard_d = 1'b0;
        end
      end
      GNT_MEM: begin
        if (bus_ack_i) begin
          mem_ack_o = 1'b1;
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      discard_q    <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      discard_q    <= discard_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_wstrb_o = bus_wstrb_q;

  assign if_rdata_o  = bus_rdata_i;
  assign mem_rdata_o = bus_rdata_i;
  assign if_stall_o  = if_req_i & ~if_ack_o;
  assign mem_stall_o = mem_req_i & ~mem_ack_o;

endmodule
